// File: rtl/apb_rr_master_arbiter_if.sv
// APB_BUS: APB bus bundle shared between the arbiter (Master) and the
// peripheral decoder (Slave).
interface APB_BUS #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter: round-robin arbiter that shares one APB master port
// between NB_REQ simple request ports and runs the SETUP/ACCESS sequence.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS phases that wait
// TIMEOUT_CYCLES cycles without pready (response flagged as error).
module apb_rr_master_arbiter #(
    parameter int NB_REQ         = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NB_REQ-1:0]                  req_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NB_REQ-1:0]                  req_we_i,
    output logic [NB_REQ-1:0]                  resp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]          resp_rdata_o,
    output logic                               resp_err_o,
    APB_BUS.Master                             apb_master
);

    localparam int OW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                    r_state;
    logic [OW-1:0]             r_owner;
    logic [OW-1:0]             r_rr_ptr;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;

    logic                      w_found;
    int                        w_idx;
    logic [OW-1:0]             w_winner;
    logic [OW-1:0]             w_next_ptr;
    logic [APB_ADDR_WIDTH-1:0] w_win_addr;
    logic [APB_DATA_WIDTH-1:0] w_win_wdata;
    logic                      w_win_we;
    logic                      w_in_access;
    logic                      w_complete;
    logic                      w_timeout;
    logic                      w_done;

`ifdef APB_TIMEOUT_EN
    logic [15:0]               r_wait_cnt;
    assign w_timeout = w_in_access && !apb_master.pready &&
                       (r_wait_cnt == 16'(TIMEOUT_CYCLES));
`else
    logic                      w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    // Round-robin search: first asserted request starting at rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (!w_found && req_i[(int'(r_rr_ptr) + k) % NB_REQ]) begin
                w_found = 1'b1;
                w_idx   = (int'(r_rr_ptr) + k) % NB_REQ;
            end
        end
    end

    assign w_winner    = OW'(w_idx);
    assign w_next_ptr  = OW'((w_idx + 1) % NB_REQ);
    assign w_win_addr  = req_addr_i[w_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
    assign w_win_wdata = req_wdata_i[w_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    assign w_win_we    = req_we_i[w_idx];

    assign w_in_access = (r_state == S_ACCESS);
    assign w_complete  = w_in_access && apb_master.pready;
    // A normal completion takes precedence over a timeout in the same cycle.
    assign w_done      = w_complete || w_timeout;

    // Completion response goes to the owner only; data/err stay 0 otherwise.
    always_comb begin
        resp_valid_o = '0;
        resp_rdata_o = '0;
        resp_err_o   = 1'b0;
        if (w_done) begin
            resp_valid_o = NB_REQ'(1) << r_owner;
            if (w_complete) begin
                resp_err_o = apb_master.pslverr;
                if (!r_pwrite) begin
                    resp_rdata_o = apb_master.prdata;
                end
            end else begin
                resp_err_o = 1'b1;
            end
        end
    end

    // Transfer FSM: grant, SETUP, ACCESS until pready (or timeout), back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_paddr   <= w_win_addr;
                        r_pwdata  <= w_win_wdata;
                        r_pwrite  <= w_win_we;
                        r_owner   <= w_winner;
                        r_rr_ptr  <= w_next_ptr;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (w_done) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign apb_master.paddr   = r_paddr;
    assign apb_master.pwdata  = r_pwdata;
    assign apb_master.pwrite  = r_pwrite;
    assign apb_master.psel    = r_psel;
    assign apb_master.penable = r_penable;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed bench for apb_rr_master_arbiter (NB_REQ=2, TIMEOUT_CYCLES=8).
module tb_apb_rr_master_arbiter;

    localparam int NB  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic            clk;
    logic            rst;
    logic [NB-1:0]   req;
    logic [NB*AW-1:0] req_addr;
    logic [NB*DW-1:0] req_wdata;
    logic [NB-1:0]   req_we;
    logic [NB-1:0]   resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;

    int n_tests;
    int n_fail;

    APB_BUS #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) apb ();

    apb_rr_master_arbiter #(
        .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_we_i     (req_we),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .apb_master   (apb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change right after the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        req = '0; req_addr = '0; req_wdata = '0; req_we = '0;
        apb.prdata = '0; apb.pready = 1'b0; apb.pslverr = 1'b0;
        cyc(); cyc(); #1;
        check("rst_psel",    64'(apb.psel),    64'd0);
        check("rst_penable", 64'(apb.penable), 64'd0);
        check("rst_pwrite",  64'(apb.pwrite),  64'd0);
        check("rst_paddr",   64'(apb.paddr),   64'd0);
        check("rst_pwdata",  64'(apb.pwdata),  64'd0);
        check("rst_rvalid",  64'(resp_valid),  64'd0);
        check("rst_rdata",   64'(resp_rdata),  64'd0);
        check("rst_err",     64'(resp_err),    64'd0);
        rst = 1'b0;

        // Single read from requester 0, zero wait states
        cyc(); req = 2'b01; req_addr[0 +: AW] = 32'h1A10_1000; req_we = 2'b00; #1;
        check("rd_idle_psel", 64'(apb.psel), 64'd0);
        cyc(); #1;
        check("rd_setup_psel",    64'(apb.psel),    64'd1);
        check("rd_setup_penable", 64'(apb.penable), 64'd0);
        check("rd_setup_paddr",   64'(apb.paddr),   64'h1A10_1000);
        check("rd_setup_pwrite",  64'(apb.pwrite),  64'd0);
        check("rd_setup_rvalid",  64'(resp_valid),  64'd0);
        cyc(); apb.pready = 1'b1; apb.prdata = 32'hCAFE_0001; #1;
        check("rd_acc_penable", 64'(apb.penable), 64'd1);
        check("rd_acc_rvalid",  64'(resp_valid),  64'b01);
        check("rd_acc_rdata",   64'(resp_rdata),  64'hCAFE_0001);
        check("rd_acc_err",     64'(resp_err),    64'd0);
        cyc(); req = 2'b00; apb.pready = 1'b0; apb.prdata = '0; #1;
        check("rd_end_psel",   64'(apb.psel),   64'd0);
        check("rd_end_rvalid", 64'(resp_valid), 64'd0);
        check("rd_end_rdata",  64'(resp_rdata), 64'd0);

        // Write from requester 1 with 3 wait states
        cyc(); req = 2'b10; req_addr[AW +: AW] = 32'h1A10_3004;
        req_wdata[DW +: DW] = 32'h0000_00FF; req_we = 2'b10; #1;
        cyc(); #1;
        check("wr_setup_psel",  64'(apb.psel),  64'd1);
        check("wr_setup_paddr", 64'(apb.paddr), 64'h1A10_3004);
        for (int i = 0; i < 4; i++) begin
            cyc(); apb.pready = (i == 3); apb.prdata = 32'h5555_AAAA; #1;
            check("wr_acc_paddr",   64'(apb.paddr),   64'h1A10_3004);
            check("wr_acc_pwdata",  64'(apb.pwdata),  64'h0000_00FF);
            check("wr_acc_pwrite",  64'(apb.pwrite),  64'd1);
            check("wr_acc_penable", 64'(apb.penable), 64'd1);
            check("wr_acc_rvalid",  64'(resp_valid),  (i == 3) ? 64'b10 : 64'b00);
            check("wr_acc_rdata",   64'(resp_rdata),  64'd0);
        end
        cyc(); req = 2'b00; apb.pready = 1'b0; apb.prdata = '0; req_we = 2'b00; #1;
        check("wr_end_psel",   64'(apb.psel),   64'd0);
        check("wr_end_rvalid", 64'(resp_valid), 64'd0);

        // Contention: both request continuously, grants alternate 0,1,0,1
        req_addr[0 +: AW]  = 32'h1A10_0100;
        req_addr[AW +: AW] = 32'h1A10_0200;
        for (int t = 0; t < 4; t++) begin
            cyc(); req = 2'b11; apb.pready = 1'b0; #1;
            check("cont_idle_psel",   64'(apb.psel),   64'd0);
            check("cont_idle_rvalid", 64'(resp_valid), 64'd0);
            cyc(); #1;
            check("cont_setup_paddr", 64'(apb.paddr),
                  (t % 2 == 0) ? 64'h1A10_0100 : 64'h1A10_0200);
            check("cont_setup_rvalid", 64'(resp_valid), 64'd0);
            cyc(); apb.pready = 1'b1; apb.prdata = 32'h100 + 32'(t); #1;
            check("cont_rvalid", 64'(resp_valid), (t % 2 == 0) ? 64'b01 : 64'b10);
            check("cont_rdata",  64'(resp_rdata), 64'h100 + 64'(t));
        end
        cyc(); req = 2'b00; apb.pready = 1'b0; apb.prdata = '0; #1;
        check("cont_end_psel", 64'(apb.psel), 64'd0);

        // Slave error on requester 0 read
        cyc(); req = 2'b01; req_addr[0 +: AW] = 32'h1A10_2000; #1;
        cyc(); #1;
        check("err_setup_paddr", 64'(apb.paddr), 64'h1A10_2000);
        cyc(); apb.pready = 1'b1; apb.pslverr = 1'b1; apb.prdata = 32'hDEAD_BEEF; #1;
        check("err_rvalid", 64'(resp_valid), 64'b01);
        check("err_err",    64'(resp_err),   64'd1);
        check("err_rdata",  64'(resp_rdata), 64'hDEAD_BEEF);
        cyc(); req = 2'b00; apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = '0; #1;
        check("err_end_err",    64'(resp_err),   64'd0);
        check("err_end_rvalid", 64'(resp_valid), 64'd0);

`ifdef APB_TIMEOUT_EN
        // Timeout: pready stuck low; abort after 8 wait cycles, then serve req1
        cyc(); req = 2'b01; req_addr[0 +: AW] = 32'h1A10_4000;
        req_addr[AW +: AW] = 32'h1A10_5000; #1;
        cyc(); req = 2'b11; #1;
        check("to_setup_paddr", 64'(apb.paddr), 64'h1A10_4000);
        for (int i = 0; i <= 8; i++) begin
            cyc(); apb.prdata = 32'h1234_5678; #1;
            check("to_rvalid", 64'(resp_valid), (i == 8) ? 64'b01 : 64'b00);
            check("to_err",    64'(resp_err),   (i == 8) ? 64'd1 : 64'd0);
            check("to_rdata",  64'(resp_rdata), 64'd0);
        end
        cyc(); req = 2'b10; apb.prdata = '0; #1;
        check("to_idle_psel", 64'(apb.psel), 64'd0);
        cyc(); #1;
        check("to_next_paddr", 64'(apb.paddr), 64'h1A10_5000);
        cyc(); apb.pready = 1'b1; apb.prdata = 32'h0000_0042; #1;
        check("to_next_rvalid", 64'(resp_valid), 64'b10);
        check("to_next_err",    64'(resp_err),   64'd0);
        check("to_next_rdata",  64'(resp_rdata), 64'h42);
        cyc(); req = 2'b00; apb.pready = 1'b0; apb.prdata = '0; #1;
`endif

        // Reset in the middle of an ACCESS phase (write so pwrite is 1)
        cyc(); req = 2'b01; req_we = 2'b01; req_addr[0 +: AW] = 32'h1A10_6000;
        req_addr[AW +: AW] = 32'h1A10_7000; #1;
        cyc(); #1;
        cyc(); #1;
        check("mr_acc_penable", 64'(apb.penable), 64'd1);
        check("mr_acc_pwrite",  64'(apb.pwrite),  64'd1);
        rst = 1'b1; #1;
        check("mr_rst_psel",    64'(apb.psel),    64'd0);
        check("mr_rst_penable", 64'(apb.penable), 64'd0);
        check("mr_rst_pwrite",  64'(apb.pwrite),  64'd0);
        check("mr_rst_rvalid",  64'(resp_valid),  64'd0);
        cyc(); rst = 1'b0; req = 2'b10; req_we = 2'b00; #1;
        check("mr_rel_psel", 64'(apb.psel), 64'd0);
        cyc(); #1;
        check("mr_rel_psel1", 64'(apb.psel),  64'd1);
        check("mr_rel_paddr", 64'(apb.paddr), 64'h1A10_7000);
        cyc(); apb.pready = 1'b1; apb.prdata = 32'h0BAD_F00D; #1;
        check("mr_rel_rvalid", 64'(resp_valid), 64'b10);
        check("mr_rel_rdata",  64'(resp_rdata), 64'h0BAD_F00D);
        cyc(); req = 2'b00; apb.pready = 1'b0; #1;
        check("mr_end_psel", 64'(apb.psel), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
